// File: rtl/cve2_lsu_load_resp.sv
// Load-response stage: extracts, extends and merges bus read beats into a writeback result.
// Misaligned (two-beat) loads are supported only when CVE2_LSU_MISALIGNED_EN is defined.
module cve2_lsu_load_resp #(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_start_i,
    input  logic [1:0]  load_type_i,
    input  logic        load_sign_ext_i,
    input  logic [1:0]  load_addr_lsb_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        busy_o
);

    // state       | meaning
    // IDLE        | no load outstanding
    // WAIT_FIRST  | load granted, waiting for the (only or first) response beat
    // WAIT_SECOND | first beat of a split load buffered, waiting for the second

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
`ifdef CVE2_LSU_MISALIGNED_EN
        WAIT_SECOND = 2'd2,
`endif
        WAIT_FIRST  = 2'd1
    } state_e;

    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_BYTE = 2'b10;

    state_e      state_q, state_d;
    logic        split_q, err_q, sign_q;
    logic [1:0]  type_q, lsb_q;
    logic        split_new, is_word_new;
    logic        capture, completing, err_done;
    logic [63:0] data_win;
    logic [31:0] shifted, ext_data;

`ifdef CVE2_LSU_MISALIGNED_EN
    logic [31:0] buf_q;
    logic        first_beat;
`endif

    // Reserved type 2'b11 behaves exactly like a word load.
    assign is_word_new = (load_type_i == 2'b00) || (load_type_i == 2'b11);
    assign split_new   = (is_word_new && (load_addr_lsb_i != 2'b00)) ||
                         ((load_type_i == TYPE_HALF) && (load_addr_lsb_i == 2'b11));

    always_comb begin
        state_d    = state_q;
        completing = 1'b0;
        capture    = 1'b0;
`ifdef CVE2_LSU_MISALIGNED_EN
        first_beat = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    capture = 1'b1;
                    state_d = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (data_rvalid_i) begin
`ifdef CVE2_LSU_MISALIGNED_EN
                    if (split_q) begin
                        first_beat = 1'b1;
                        state_d    = WAIT_SECOND;
                    end else begin
                        completing = 1'b1;
                    end
`else
                    completing = 1'b1;
`endif
                end
            end
`ifdef CVE2_LSU_MISALIGNED_EN
            WAIT_SECOND: begin
                if (data_rvalid_i) begin
                    completing = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A new grant on the completing beat chains straight into the next load.
        if (completing) begin
            state_d = IDLE;
            if (load_start_i) begin
                capture = 1'b1;
                state_d = WAIT_FIRST;
            end
        end

        if (!rst_ni) begin
            completing = 1'b0;
            capture    = 1'b0;
`ifdef CVE2_LSU_MISALIGNED_EN
            first_beat = 1'b0;
`endif
        end
    end

`ifdef CVE2_LSU_MISALIGNED_EN
    assign err_done = err_q | data_err_i;
    assign data_win = split_q ? {data_rdata_i, buf_q} : {32'b0, data_rdata_i};
`else
    // Without two-beat support a split-class load is reported as a misaligned fault.
    assign err_done = err_q | data_err_i | split_q;
    assign data_win = {32'b0, data_rdata_i};
`endif

    assign shifted = 32'(data_win >> {lsb_q, 3'b000});

    always_comb begin
        case (type_q)
            TYPE_BYTE: ext_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            TYPE_HALF: ext_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default:   ext_data = shifted;
        endcase
    end

    assign lsu_resp_valid_o = completing;
    assign lsu_resp_err_o   = completing & err_done;
    assign rf_we_lsu_o      = completing & ~err_done;
    assign rf_wdata_lsu_o   = rf_we_lsu_o ? ext_data : 32'b0;
    assign busy_o           = rst_ni && (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            if (ResetAll) begin
                type_q <= 2'b00;
                sign_q <= 1'b0;
                lsb_q  <= 2'b00;
`ifdef CVE2_LSU_MISALIGNED_EN
                buf_q  <= 32'b0;
`endif
            end
        end else begin
            state_q <= state_d;
            if (capture) begin
                split_q <= split_new;
                err_q   <= 1'b0;
                type_q  <= load_type_i;
                sign_q  <= load_sign_ext_i;
                lsb_q   <= load_addr_lsb_i;
            end
`ifdef CVE2_LSU_MISALIGNED_EN
            else if (first_beat) begin
                err_q <= err_q | data_err_i;
            end
            if (first_beat) begin
                buf_q <= data_rdata_i;
            end
`endif
        end
    end

`ifndef SYNTHESIS
    // A reset during an outstanding load leaves one stale response on the bus; allow it in IDLE.
    logic stale_ok_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stale_ok_q <= stale_ok_q | (state_q != IDLE);
        end else if (data_rvalid_i || load_start_i) begin
            stale_ok_q <= 1'b0;
        end
    end

    a_out_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({rf_we_lsu_o, lsu_resp_err_o}));
    a_we_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rf_we_lsu_o |-> lsu_resp_valid_o);
    a_no_start_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(load_start_i && (state_q != IDLE) && !completing));
    a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(data_rvalid_i && (state_q == IDLE) && !stale_ok_q));
`endif

endmodule

// File: tb/tb_cve2_lsu_load_resp.sv
// Directed bench for cve2_lsu_load_resp; expectations follow CVE2_LSU_MISALIGNED_EN.
module tb_cve2_lsu_load_resp;

    localparam logic [1:0] LW = 2'b00;
    localparam logic [1:0] LH = 2'b01;
    localparam logic [1:0] LB = 2'b10;
    localparam logic [1:0] LR = 2'b11;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        load_start_i = 1'b0;
    logic [1:0]  load_type_i = 2'b00;
    logic        load_sign_ext_i = 1'b0;
    logic [1:0]  load_addr_lsb_i = 2'b00;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'b0;
    logic        data_err_i = 1'b0;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;
    logic        busy_o;

    int tests_run = 0;
    int tests_failed = 0;

    cve2_lsu_load_resp dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .load_start_i     (load_start_i),
        .load_type_i      (load_type_i),
        .load_sign_ext_i  (load_sign_ext_i),
        .load_addr_lsb_i  (load_addr_lsb_i),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i),
        .data_err_i       (data_err_i),
        .rf_wdata_lsu_o   (rf_wdata_lsu_o),
        .rf_we_lsu_o      (rf_we_lsu_o),
        .lsu_resp_valid_o (lsu_resp_valid_o),
        .lsu_resp_err_o   (lsu_resp_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic we, input logic er,
                              input logic [31:0] wd, input logic bsy);
        check({tag, ".valid"}, 32'(lsu_resp_valid_o), 32'(v));
        check({tag, ".we"},    32'(rf_we_lsu_o),      32'(we));
        check({tag, ".err"},   32'(lsu_resp_err_o),   32'(er));
        check({tag, ".wdata"}, rf_wdata_lsu_o,        wd);
        check({tag, ".busy"},  32'(busy_o),           32'(bsy));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic start, input logic [1:0] ty, input logic sx,
                         input logic [1:0] lsb, input logic rv, input logic [31:0] rd,
                         input logic er);
        @(negedge clk);
        load_start_i    = start;
        load_type_i     = ty;
        load_sign_ext_i = sx;
        load_addr_lsb_i = lsb;
        data_rvalid_i   = rv;
        data_rdata_i    = rd;
        data_err_i      = er;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, LW, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic single(input string tag, input logic [1:0] ty, input logic sx,
                          input logic [1:0] lsb, input logic [31:0] rd, input logic er,
                          input logic [31:0] exp_wd);
        drive(1'b1, ty, sx, lsb, 1'b0, 32'h0, 1'b0);
        expect_out({tag, "_grant"}, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, ty, sx, lsb, 1'b1, rd, er);
        expect_out(tag, 1'b1, ~er, er, er ? 32'h0 : exp_wd, 1'b1);
        idle();
        expect_out({tag, "_done"}, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        idle();
        expect_out("in_reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        idle();
        expect_out("post_reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        single("lb_sx",   LB, 1'b1, 2'd2, 32'h12803456, 1'b0, 32'hFFFFFF80);
        single("lhu",     LH, 1'b0, 2'd1, 32'hAABBCCDD, 1'b0, 32'h0000BBCC);
        single("lbu_b3",  LB, 1'b0, 2'd3, 32'hF0000000, 1'b0, 32'h000000F0);
        single("lb_pos",  LB, 1'b1, 2'd0, 32'h0000807F, 1'b0, 32'h0000007F);
        single("lh_sx",   LH, 1'b1, 2'd2, 32'h80011234, 1'b0, 32'hFFFF8001);
        single("lw",      LW, 1'b0, 2'd0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        single("lresv",   LR, 1'b1, 2'd0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);
        single("lw_err",  LW, 1'b0, 2'd0, 32'h12345678, 1'b1, 32'h0);

        // Misaligned word
        drive(1'b1, LW, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, LW, 1'b0, 2'd1, 1'b1, 32'h44332211, 1'b0);
`ifdef CVE2_LSU_MISALIGNED_EN
        expect_out("lw_mis_b1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, LW, 1'b0, 2'd1, 1'b1, 32'h88776655, 1'b0);
        expect_out("lw_mis_b2", 1'b1, 1'b1, 1'b0, 32'h55443322, 1'b1);
`else
        expect_out("lw_mis_fault", 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
`endif
        idle();
        expect_out("lw_mis_done", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Misaligned half at lsb=3
        drive(1'b1, LH, 1'b1, 2'd3, 1'b0, 32'h0, 1'b0);
        drive(1'b0, LH, 1'b1, 2'd3, 1'b1, 32'h80AAAAAA, 1'b0);
`ifdef CVE2_LSU_MISALIGNED_EN
        expect_out("lh_mis_b1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, LH, 1'b1, 2'd3, 1'b1, 32'h555555FF, 1'b0);
        expect_out("lh_mis_b2", 1'b1, 1'b1, 1'b0, 32'hFFFFFF80, 1'b1);
`else
        expect_out("lh_mis_fault", 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
`endif
        idle();

        // Split load with first-beat error, then back-to-back lbu
        drive(1'b1, LW, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
`ifdef CVE2_LSU_MISALIGNED_EN
        drive(1'b0, LW, 1'b0, 2'd2, 1'b1, 32'h11111111, 1'b1);
        expect_out("err_b1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b1, LB, 1'b0, 2'd0, 1'b1, 32'h22222222, 1'b0);
        expect_out("err_b2", 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
`else
        drive(1'b1, LB, 1'b0, 2'd0, 1'b1, 32'h11111111, 1'b1);
        expect_out("err_b1", 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
`endif
        drive(1'b0, LW, 1'b0, 2'd0, 1'b1, 32'h000000C3, 1'b0);
        expect_out("b2b_lbu", 1'b1, 1'b1, 1'b0, 32'h000000C3, 1'b1);
        idle();
        expect_out("b2b_done", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset while a load is outstanding
`ifdef CVE2_LSU_MISALIGNED_EN
        drive(1'b1, LW, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0);
        drive(1'b0, LW, 1'b0, 2'd3, 1'b1, 32'h01020304, 1'b0);
        expect_out("pre_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
`else
        drive(1'b1, LW, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        idle();
        expect_out("pre_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
`endif
        @(negedge clk);
        rst_ni        = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h05060708;
        #1;
        expect_out("mid_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_ni        = 1'b1;
        data_rvalid_i = 1'b0;
        #1;
        expect_out("after_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, LW, 1'b0, 2'd0, 1'b1, 32'h09090909, 1'b0);
        expect_out("stale_rvalid", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        single("lw_after_rst", LW, 1'b0, 2'd0, 32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
